// File: rtl/clock_freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of i_Sig over a
// fixed window of GATE_CYCLES i_Clk cycles and reports the count once per window.
module clock_freq_meter #(
  parameter int unsigned CLK_IN      = 100000000,
  parameter logic [31:0] GATE_CYCLES = 32'd100000000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Sig,
  input  logic                   i_Start,
  input  logic                   i_Continuous,
  output logic [COUNT_WIDTH-1:0] o_Count,
  output logic                   o_Valid,
  output logic                   o_Busy,
  output logic                   o_Overflow
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE_EDGE = COUNT_WIDTH'(1);
  localparam logic [31:0]            LAST_GATE_CNT = GATE_CYCLES - 32'd1;

  // Reject parameter values the counters cannot honour
  if (GATE_CYCLES < 32'd2) begin : g_bad_gate
    $error("clock_freq_meter: GATE_CYCLES must be at least 2");
  end
  if (COUNT_WIDTH < 4 || COUNT_WIDTH > 32) begin : g_bad_width
    $error("clock_freq_meter: COUNT_WIDTH must be 4..32");
  end
  if (CLK_IN < 2) begin : g_bad_clk
    $error("clock_freq_meter: CLK_IN must be at least 2 Hz");
  end

  state_t                 state;
  logic                   sync_1;
  logic                   sync_2;
  logic                   sig_prev;
  logic [31:0]            gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt;
  logic                   sat_flag;

  logic                   edge_det;
  logic                   last_gate;
  logic [COUNT_WIDTH-1:0] edge_next;
  logic                   sat_next;

  // Two-flop synchronizer plus a history flop for edge detection; runs in every state
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sync_1   <= i_Sig;
      sync_2   <= sync_1;
      sig_prev <= sync_2;
    end
  end

  // Next edge-count and saturation values, so the final gate cycle's edge lands in the result
  always_comb begin
    edge_det  = sync_2 & ~sig_prev;
    last_gate = (gate_cnt == LAST_GATE_CNT);
    edge_next = edge_cnt;
    sat_next  = sat_flag;
    if (edge_det) begin
      if (&edge_cnt) begin
        sat_next = 1'b1;
      end else begin
        edge_next = edge_cnt + ONE_EDGE;
      end
    end
  end

  // Measurement FSM with registered result, strobe and busy outputs
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state      <= IDLE;
      gate_cnt   <= 32'd0;
      edge_cnt   <= '0;
      sat_flag   <= 1'b0;
      o_Count    <= '0;
      o_Valid    <= 1'b0;
      o_Busy     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start || i_Continuous) begin
            state    <= GATE;
            gate_cnt <= 32'd0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
            o_Busy   <= 1'b1;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + 32'd1;
          edge_cnt <= edge_next;
          sat_flag <= sat_next;
          if (last_gate) begin
            state      <= DONE;
            o_Count    <= edge_next;
            o_Overflow <= sat_next;
            o_Valid    <= 1'b1;
            o_Busy     <= 1'b0;
          end
        end
        DONE: begin
          if (i_Continuous) begin
            state    <= GATE;
            gate_cnt <= 32'd0;
            edge_cnt <= '0;
            sat_flag <= 1'b0;
            o_Busy   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
